// File: rtl/bp_zynq_bedrock_mailbox_responder_pkg.sv
// bp_zynq_bedrock_mailbox_responder_pkg: BedRock header/enum types and lane helpers for the mailbox responder
// Ports: none (types, localparams and helper functions only)
package bp_zynq_bedrock_mailbox_responder_pkg;
  localparam int paddr_width_p = 40;
  localparam int data_width_p = 64;
  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1  = 3'd0,
    e_bedrock_msg_size_2  = 3'd1,
    e_bedrock_msg_size_4  = 3'd2,
    e_bedrock_msg_size_8  = 3'd3,
    e_bedrock_msg_size_16 = 3'd4,
    e_bedrock_msg_size_32 = 3'd5,
    e_bedrock_msg_size_64 = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;
  typedef struct packed {
    logic [15:0]               payload;
    bp_bedrock_msg_size_e      size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    bp_bedrock_mem_type_e      msg_type;
  } bp_bedrock_mem_header_s;
  typedef bp_bedrock_mem_header_s bp_bedrock_mem_fwd_header_s;
  typedef bp_bedrock_mem_header_s bp_bedrock_mem_rev_header_s;
  function automatic logic [7:0] byte_mask(logic [2:0] sz, logic [2:0] off);
    logic [8:0] m;
    m = (9'd1 << (4'd1 << sz[1:0])) - 9'd1;
    return m[7:0] << off;
  endfunction
  // Sizes above 8B cannot be served by a 64b register, so they count as misaligned.
  function automatic logic misaligned(logic [2:0] sz, logic [2:0] off);
    logic [2:0] lo;
    lo = 3'((4'd1 << sz[1:0]) - 4'd1);
    return sz[2] | (|(off & lo));
  endfunction
endpackage

// File: rtl/bp_zynq_bedrock_mailbox_responder_if.sv
// bp_zynq_bedrock_mailbox_responder_if: BedRock mem_fwd/mem_rev single-beat handshake bundle
// Ports: fwd_* (BP -> responder request), rev_* (responder -> BP response); master = BP side, slave = responder
interface bp_zynq_bedrock_mailbox_responder_if
  import bp_zynq_bedrock_mailbox_responder_pkg::*;
  ;
  bp_bedrock_mem_fwd_header_s fwd_header;
  logic [data_width_p-1:0]    fwd_data;
  logic                       fwd_v;
  logic                       fwd_ready_and;
  logic                       fwd_last;
  bp_bedrock_mem_rev_header_s rev_header;
  logic [data_width_p-1:0]    rev_data;
  logic                       rev_v;
  logic                       rev_ready_and;
  logic                       rev_last;
  modport master (
    output fwd_header, fwd_data, fwd_v, fwd_last, rev_ready_and,
    input  fwd_ready_and, rev_header, rev_data, rev_v, rev_last
  );
  modport slave (
    input  fwd_header, fwd_data, fwd_v, fwd_last, rev_ready_and,
    output fwd_ready_and, rev_header, rev_data, rev_v, rev_last
  );
endinterface

// File: rtl/bp_zynq_bedrock_mailbox_responder_lane_merge.sv
// bp_zynq_mailbox_lane_merge: byte-mask merge for writes, extract+replicate for reads
// Ports: old_data (current reg), wr_data (lane-positioned write data), offset/size (access shape),
//        merged (reg after write), rd_data (selected bytes zero-extended and replicated to 64b)
module bp_zynq_mailbox_lane_merge
  import bp_zynq_bedrock_mailbox_responder_pkg::*;
(
  input  logic [63:0]          old_data,
  input  logic [63:0]          wr_data,
  input  logic [2:0]           offset,
  input  bp_bedrock_msg_size_e size,
  output logic [63:0]          merged,
  output logic [63:0]          rd_data
);
  logic [7:0]  mask;
  logic [63:0] bit_mask;
  logic [63:0] shifted;
  assign mask = byte_mask(size, offset);
  for (genvar b = 0; b < 8; b++) begin : g_mask
    assign bit_mask[8*b+:8] = {8{mask[b]}};
  end
  assign merged = (old_data & ~bit_mask) | (wr_data & bit_mask);
  assign shifted = old_data >> {offset, 3'b000};
  always_comb begin
    rd_data = size == e_bedrock_msg_size_1 ? {8{shifted[7:0]}}
            : size == e_bedrock_msg_size_2 ? {4{shifted[15:0]}}
            : size == e_bedrock_msg_size_4 ? {2{shifted[31:0]}}
            : shifted;
  end
endmodule

// File: rtl/bp_zynq_bedrock_mailbox_responder.sv
// bp_zynq_bedrock_mailbox_responder: BedRock uncached responder backed by a PS-shared mailbox register file
// Ports: clk_i/reset_i (async active-high); mem (slave side of fwd/rev handshake);
//        ps_addr_i/ps_w_v_i/ps_data_i (PS write port, wins on collision), ps_data_o (comb PS read);
//        pending_o (per-reg BP-wrote flag, cleared by PS write), error_o (sticky unsupported/misaligned)
module bp_zynq_bedrock_mailbox_responder
  import bp_zynq_bedrock_mailbox_responder_pkg::*;
#(
  parameter  int els_p     = 8,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bp_zynq_bedrock_mailbox_responder_if.slave mem,
  input  logic [lg_els_lp-1:0] ps_addr_i,
  input  logic                 ps_w_v_i,
  input  logic [63:0]          ps_data_i,
  output logic [63:0]          ps_data_o,
  output logic [els_p-1:0]     pending_o,
  output logic                 error_o
);
  typedef enum logic {e_ready, e_resp} state_e;
  state_e                     state, state_n;
  logic [63:0]                mailbox [els_p];
  bp_bedrock_mem_fwd_header_s fwd;
  bp_bedrock_mem_rev_header_s rev_header;
  logic [63:0]                rev_data;
  logic [lg_els_lp-1:0]       idx;
  logic [2:0]                 off;
  logic                       fwd_hs, is_wr, is_rd, bad_align, bp_wr, err;
  logic [63:0]                merged, rd_data;
  logic                       unused_last;
  assign fwd = mem.fwd_header;
  assign idx = fwd.addr[3+:lg_els_lp];
  assign off = fwd.addr[2:0];
  assign fwd_hs = mem.fwd_v & (state == e_ready) & ~reset_i;
  assign is_wr = fwd.msg_type == e_bedrock_mem_uc_wr;
  assign is_rd = fwd.msg_type == e_bedrock_mem_uc_rd;
  assign bad_align = misaligned(fwd.size, off);
  assign bp_wr = fwd_hs & is_wr & ~bad_align;
  assign err = fwd_hs & (~(is_wr | is_rd) | bad_align);
  assign unused_last = mem.fwd_last;
  bp_zynq_mailbox_lane_merge lane_merge (
    .old_data(mailbox[idx]),
    .wr_data (mem.fwd_data),
    .offset  (off),
    .size    (fwd.size),
    .merged  (merged),
    .rd_data (rd_data)
  );
  assign mem.fwd_ready_and = (state == e_ready) & ~reset_i;
  assign mem.rev_v = state == e_resp;
  assign mem.rev_header = rev_header;
  assign mem.rev_data = rev_data;
  assign mem.rev_last = 1'b1;
  assign ps_data_o = mailbox[ps_addr_i];
  always_comb begin
    state_n = state;
    if (state == e_ready && fwd_hs) state_n = e_resp;
    if (state == e_resp && mem.rev_ready_and) state_n = e_ready;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= e_ready;
    else state <= state_n;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mailbox[i] <= '0;
      pending_o <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (ps_w_v_i && ps_addr_i == lg_els_lp'(i)) begin
          mailbox[i] <= ps_data_i;
          pending_o[i] <= 1'b0;
        end else if (bp_wr && idx == lg_els_lp'(i)) begin
          mailbox[i] <= merged;
          pending_o[i] <= 1'b1;
        end
      end
    end
  end
  // Read data is captured from the pre-edge register value, so a colliding PS write is not visible.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rev_header <= '0;
      rev_data <= '0;
      error_o <= 1'b0;
    end else begin
      if (fwd_hs) begin
        rev_header <= fwd;
        rev_data <= (is_rd & ~bad_align) ? rd_data : '0;
      end
      if (err) error_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bp_zynq_bedrock_mailbox_responder.sv
// tb_bp_zynq_bedrock_mailbox_responder: directed self-checking bench for the mailbox responder
module tb_bp_zynq_bedrock_mailbox_responder;
  import bp_zynq_bedrock_mailbox_responder_pkg::*;
  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [2:0]  ps_addr_i = '0;
  logic        ps_w_v_i = 1'b0;
  logic [63:0] ps_data_i = '0;
  logic [63:0] ps_data_o;
  logic [7:0]  pending_o;
  logic        error_o;
  int          checks = 0;
  int          errors = 0;
  bp_bedrock_mem_header_s h, h2;
  bp_zynq_bedrock_mailbox_responder_if bus();
  bp_zynq_bedrock_mailbox_responder dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .mem      (bus.slave),
    .ps_addr_i(ps_addr_i),
    .ps_w_v_i (ps_w_v_i),
    .ps_data_i(ps_data_i),
    .ps_data_o(ps_data_o),
    .pending_o(pending_o),
    .error_o  (error_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bp_bedrock_mem_header_s mk(bp_bedrock_mem_type_e t, bp_bedrock_msg_size_e s, logic [39:0] a);
    mk = '0;
    mk.msg_type = t;
    mk.size = s;
    mk.addr = a;
    mk.payload = 16'hA5A5;
  endfunction
  task automatic send(bp_bedrock_mem_header_s hdr, logic [63:0] d);
    bus.fwd_header = hdr;
    bus.fwd_data = d;
    bus.fwd_v = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.fwd_v = 1'b0;
    ps_w_v_i = 1'b0;
  endtask
  task automatic finish_rev(string tag);
    bus.rev_ready_and = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.rev_ready_and = 1'b0;
    check(tag, bus.rev_v, 1'b0);
  endtask
  task automatic peek(logic [2:0] a, string tag, logic [63:0] exp);
    ps_addr_i = a;
    #1;
    check(tag, ps_data_o, exp);
  endtask
  initial begin
    bus.fwd_header = '0;
    bus.fwd_data = '0;
    bus.fwd_v = 1'b0;
    bus.fwd_last = 1'b1;
    bus.rev_ready_and = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_fwd_ready", bus.fwd_ready_and, 1'b0);
    check("rst_rev_v", bus.rev_v, 1'b0);
    check("rst_pending", pending_o, 8'h00);
    check("rst_error", error_o, 1'b0);
    peek(3'd0, "rst_mbox0", 64'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("idle_fwd_ready", bus.fwd_ready_and, 1'b1);
    // full-width write to reg 2
    @(negedge clk_i);
    h = mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h10);
    send(h, 64'hDEAD_BEEF_0123_4567);
    check("wr8_rev_v", bus.rev_v, 1'b1);
    check("wr8_fwd_ready", bus.fwd_ready_and, 1'b0);
    check("wr8_rev_hdr", bus.rev_header, h);
    check("wr8_rev_data", bus.rev_data, 64'h0);
    check("wr8_rev_last", bus.rev_last, 1'b1);
    check("wr8_pending", pending_o, 8'h04);
    peek(3'd2, "wr8_mbox2", 64'hDEAD_BEEF_0123_4567);
    finish_rev("wr8_rev_done");
    // halfword read at offset 6, replicated
    send(mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_2, 40'h16), 64'h0);
    check("rd2_rev_data", bus.rev_data, 64'hDEAD_DEAD_DEAD_DEAD);
    check("rd2_pending", pending_o, 8'h04);
    finish_rev("rd2_rev_done");
    // PS and BP write same reg 3: PS wins, pending stays clear
    ps_w_v_i = 1'b1;
    ps_addr_i = 3'd3;
    ps_data_i = 64'h55;
    send(mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h18), 64'hAA);
    peek(3'd3, "coll_mbox3", 64'h55);
    check("coll_pending", pending_o, 8'h04);
    finish_rev("coll_rev_done");
    // PS writes reg 2 while BP writes byte 1 of reg 4
    ps_w_v_i = 1'b1;
    ps_addr_i = 3'd2;
    ps_data_i = 64'h11;
    send(mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_1, 40'h21), 64'h0000_0000_0000_BB00);
    check("diff_pending", pending_o, 8'h10);
    peek(3'd2, "diff_mbox2", 64'h11);
    peek(3'd4, "diff_mbox4", 64'hBB00);
    finish_rev("diff_rev_done");
    // BP read of reg 4 while PS overwrites it: old value returned
    ps_w_v_i = 1'b1;
    ps_addr_i = 3'd4;
    ps_data_i = 64'h77;
    h = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_8, 40'h20);
    send(h, 64'h0);
    check("rdold_rev_data", bus.rev_data, 64'hBB00);
    check("rdold_pending", pending_o, 8'h00);
    peek(3'd4, "rdold_mbox4", 64'h77);
    // back-pressure: response held, next request blocked
    h2 = mk(e_bedrock_mem_uc_rd, e_bedrock_msg_size_1, 40'h20);
    bus.fwd_header = h2;
    bus.fwd_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("hold_rev_v", bus.rev_v, 1'b1);
      check("hold_fwd_ready", bus.fwd_ready_and, 1'b0);
      check("hold_rev_hdr", bus.rev_header, h);
      check("hold_rev_data", bus.rev_data, 64'hBB00);
    end
    bus.rev_ready_and = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("release_rev_v", bus.rev_v, 1'b0);
    check("release_fwd_ready", bus.fwd_ready_and, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.fwd_v = 1'b0;
    check("next_rev_v", bus.rev_v, 1'b1);
    check("next_rev_hdr", bus.rev_header, h2);
    check("next_rev_data", bus.rev_data, 64'h7777_7777_7777_7777);
    finish_rev("next_rev_done");
    // misaligned word write
    check("pre_mis_error", error_o, 1'b0);
    send(mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_4, 40'h02), 64'hFFFF_FFFF_FFFF_FFFF);
    check("mis_error", error_o, 1'b1);
    check("mis_rev_v", bus.rev_v, 1'b1);
    check("mis_rev_data", bus.rev_data, 64'h0);
    check("mis_pending", pending_o, 8'h00);
    peek(3'd0, "mis_mbox0", 64'h0);
    finish_rev("mis_rev_done");
    // async reset while a response is pending
    send(mk(e_bedrock_mem_uc_wr, e_bedrock_msg_size_8, 40'h28), 64'h1234);
    check("prerst_rev_v", bus.rev_v, 1'b1);
    peek(3'd5, "prerst_mbox5", 64'h1234);
    reset_i = 1'b1;
    #1;
    check("midrst_rev_v", bus.rev_v, 1'b0);
    check("midrst_fwd_ready", bus.fwd_ready_and, 1'b0);
    check("midrst_error", error_o, 1'b0);
    check("midrst_pending", pending_o, 8'h00);
    peek(3'd5, "midrst_mbox5", 64'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    // unsupported amo
    @(negedge clk_i);
    h = mk(e_bedrock_mem_amo, e_bedrock_msg_size_8, 40'h08);
    send(h, 64'hFFFF_FFFF_FFFF_FFFF);
    check("amo_rev_v", bus.rev_v, 1'b1);
    check("amo_error", error_o, 1'b1);
    check("amo_rev_hdr", bus.rev_header, h);
    check("amo_rev_data", bus.rev_data, 64'h0);
    check("amo_pending", pending_o, 8'h00);
    peek(3'd1, "amo_mbox1", 64'h0);
    finish_rev("amo_rev_done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
